// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: debounced single-step / free-run clock generator for a CPU datapath.
// Generates cpu_clk from clk_in with selectable run rates, single steps and halt handling.
module cpu_clk_ctrl #(
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned HALF0      = 50000000,
    parameter int unsigned HALF1      = 5000000,
    parameter int unsigned HALF2      = 500000,
    parameter int unsigned HALF3      = 50,
    parameter int unsigned STEP_HI    = 4
) (
    input  logic        clk_in,
    input  logic        RST,
    input  logic        step_btn,
    input  logic        run_sw,
    input  logic [1:0]  speed,
    input  logic        halt_in,
    output logic        cpu_clk,
    output logic        running,
    output logic        halted,
    output logic [31:0] cycle_cnt
);
    localparam logic [31:0] DEB = (DEB_CYCLES == 0) ? 32'd1 : 32'(DEB_CYCLES);
    localparam logic [31:0] H0  = (HALF0 == 0) ? 32'd1 : 32'(HALF0);
    localparam logic [31:0] H1  = (HALF1 == 0) ? 32'd1 : 32'(HALF1);
    localparam logic [31:0] H2  = (HALF2 == 0) ? 32'd1 : 32'(HALF2);
    localparam logic [31:0] H3  = (HALF3 == 0) ? 32'd1 : 32'(HALF3);
    localparam logic [31:0] SHI = (STEP_HI == 0) ? 32'd1 : 32'(STEP_HI);

    typedef enum logic [2:0] {IDLE, STEP_H, STEP_L, RUN, HALTED} state_t;

    logic [1:0]  s1, s2, deb, vld;
    logic [31:0] dcnt [2];
    logic        step_prev, armed, step_ev, run_deb;
    state_t      state, state_n;
    logic [31:0] cnt, cnt_n, half;
    logic        clk_n;

    // bit 0 = step button, bit 1 = run switch
    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            s1        <= '0;
            s2        <= '0;
            deb       <= '0;
            vld       <= '0;
            dcnt[0]   <= '0;
            dcnt[1]   <= '0;
            step_prev <= 1'b0;
            armed     <= 1'b0;
        end else begin
            s1        <= {run_sw, step_btn};
            s2        <= s1;
            vld       <= {vld[0], 1'b1};
            step_prev <= deb[0];
            // a button held through reset must be released before it can step again
            armed     <= armed | (vld[1] & ~s2[0]);
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == deb[i])
                    dcnt[i] <= '0;
                else if (dcnt[i] == DEB - 32'd1) begin
                    deb[i]  <= s2[i];
                    dcnt[i] <= '0;
                end else
                    dcnt[i] <= dcnt[i] + 32'd1;
            end
        end
    end

    assign step_ev = deb[0] & ~step_prev & armed;
    assign run_deb = deb[1];

    always_comb begin
        half = (speed == 2'd0) ? H0 : (speed == 2'd1) ? H1 : (speed == 2'd2) ? H2 : H3;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        clk_n   = cpu_clk;
        case (state)
            IDLE: begin
                clk_n = 1'b0;
                if (run_deb) begin
                    state_n = RUN;
                    cnt_n   = half - 32'd1;
                end else if (step_ev) begin
                    state_n = STEP_H;
                    clk_n   = 1'b1;
                    cnt_n   = SHI - 32'd1;
                end
            end
            STEP_H: begin
                if (cnt != 0)
                    cnt_n = cnt - 32'd1;
                else begin
                    state_n = STEP_L;
                    clk_n   = 1'b0;
                    cnt_n   = SHI - 32'd1;
                end
            end
            STEP_L: begin
                if (cnt != 0)
                    cnt_n = cnt - 32'd1;
                else
                    state_n = halt_in ? HALTED : IDLE;
            end
            // halt and run_sw are honoured only at the end of a low half
            RUN: begin
                if (cnt != 0)
                    cnt_n = cnt - 32'd1;
                else if (cpu_clk) begin
                    clk_n = 1'b0;
                    cnt_n = half - 32'd1;
                end else if (halt_in)
                    state_n = HALTED;
                else if (!run_deb)
                    state_n = IDLE;
                else begin
                    clk_n = 1'b1;
                    cnt_n = half - 32'd1;
                end
            end
            HALTED: begin
                clk_n = 1'b0;
                if (!run_deb && step_ev)
                    state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                clk_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            cnt       <= '0;
            cpu_clk   <= 1'b0;
            running   <= 1'b0;
            halted    <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            cpu_clk <= clk_n;
            running <= (state_n == RUN);
            halted  <= (state_n == HALTED);
            if (clk_n && !cpu_clk && cycle_cnt != '1)
                cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb_cpu_clk_ctrl: directed bench for cpu_clk_ctrl; expected pulse widths are queued
// when stimulus is applied and popped when cpu_clk falls.
module tb_cpu_clk_ctrl;
    logic        clk_in = 1'b0;
    logic        RST = 1'b0;
    logic        step_btn = 1'b0;
    logic        run_sw = 1'b0;
    logic [1:0]  speed = 2'd0;
    logic        halt_in = 1'b0;
    logic        cpu_clk, running, halted;
    logic [31:0] cycle_cnt;

    int n_checks = 0;
    int n_pass = 0;
    int exp_q[$];
    int exp_cc = 0;
    int hi_len = 0;
    logic prev = 1'b0;

    cpu_clk_ctrl #(
        .DEB_CYCLES(4), .HALF0(16), .HALF1(8), .HALF2(4), .HALF3(2), .STEP_HI(3)
    ) dut (
        .clk_in(clk_in), .RST(RST), .step_btn(step_btn), .run_sw(run_sw),
        .speed(speed), .halt_in(halt_in), .cpu_clk(cpu_clk), .running(running),
        .halted(halted), .cycle_cnt(cycle_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Each completed high pulse is compared against the oldest queued width; an
    // unexpected pulse is compared against 0.
    always @(negedge clk_in) begin
        if (!RST) begin
            hi_len = 0;
            prev   = 1'b0;
        end else begin
            if (cpu_clk === 1'b1)
                hi_len++;
            else if (prev) begin
                int e;
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 0;
                check("pulse_hi", hi_len, e);
                hi_len = 0;
            end
            prev = cpu_clk;
        end
    end

    task automatic next_rise(input int exp_hi, output int lo);
        int n;
        n  = 0;
        lo = 0;
        while (cpu_clk === 1'b1 && n < 200) begin tick(1); n++; end
        while (cpu_clk !== 1'b1 && n < 200) begin tick(1); n++; lo++; end
        check("rise_timeout", n < 200, 1);
        exp_q.push_back(exp_hi);
        exp_cc++;
        check("cycle_cnt_rise", cycle_cnt, exp_cc);
    endtask

    task automatic press(input bit pulse);
        if (pulse) begin
            exp_q.push_back(3);
            exp_cc++;
        end
        step_btn = 1'b1;
        tick(12);
        step_btn = 1'b0;
        tick(12);
        check("cycle_cnt_press", cycle_cnt, exp_cc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lo, n;
        logic [3:0] bounce;
        bounce = 4'b1010;
        tick(3);
        check("rst_cpu_clk", cpu_clk, 0);
        check("rst_running", running, 0);
        check("rst_halted", halted, 0);
        check("rst_cycle_cnt", cycle_cnt, 0);
        RST = 1'b1;
        tick(4);

        // bouncing press then held: exactly one 3-cycle pulse
        for (int i = 3; i >= 0; i--) begin
            step_btn = bounce[i];
            tick(1);
        end
        exp_q.push_back(3);
        exp_cc++;
        step_btn = 1'b1;
        tick(20);
        check("bounce_cc", cycle_cnt, 1);
        check("bounce_clk", cpu_clk, 0);
        check("bounce_running", running, 0);
        check("bounce_halted", halted, 0);
        step_btn = 1'b0;
        tick(10);

        // free run at speed 2: 4 high / 4 low
        speed  = 2'd2;
        run_sw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            next_rise(4, lo);
            if (i > 0) check("run_lo", lo, 4);
        end
        check("run_running", running, 1);
        check("run_halted", halted, 0);
        check("run_cc", cycle_cnt, 11);

        // speed change mid-high: this half stays 4, later halves 16
        tick(1);
        speed = 2'd0;
        next_rise(16, lo);
        check("spd_lo16_a", lo, 16);
        next_rise(16, lo);
        check("spd_lo16_b", lo, 16);

        // halt during a high half: low half (speed 2 -> 4 cycles) completes, then HALTED
        speed   = 2'd2;
        halt_in = 1'b1;
        n = 0;
        while (cpu_clk === 1'b1 && n < 100) begin tick(1); n++; end
        check("halt_fall_seen", cpu_clk, 0);
        n = 0;
        while (halted !== 1'b1 && n < 100) begin tick(1); n++; end
        check("halt_low_len", n, 4);
        check("halt_running", running, 0);
        check("halt_clk", cpu_clk, 0);
        press(0);
        press(0);
        check("halt_stays", halted, 1);

        // leave HALTED: clear run_sw, then a step press
        run_sw = 1'b0;
        tick(10);
        check("halt_needs_step", halted, 1);
        halt_in = 1'b0;
        press(0);
        check("unhalt_halted", halted, 0);
        check("unhalt_running", running, 0);
        press(1);
        check("post_halt_cc", cycle_cnt, 14);

        // reset during STEP_H truncates the pulse; held button does nothing afterwards
        step_btn = 1'b1;
        n = 0;
        while (cpu_clk !== 1'b1 && n < 30) begin tick(1); n++; end
        check("step_hi_seen", cpu_clk, 1);
        #2 RST = 1'b0;
        #1;
        check("rst_mid_clk", cpu_clk, 0);
        check("rst_mid_cc", cycle_cnt, 0);
        exp_cc = 0;
        tick(2);
        RST = 1'b1;
        tick(20);
        check("post_rst_cc", cycle_cnt, exp_cc);
        check("post_rst_clk", cpu_clk, 0);
        check("post_rst_running", running, 0);
        check("post_rst_halted", halted, 0);
        step_btn = 1'b0;
        tick(5);
        check("sb_drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
